// File: rtl/option22_seq_ctrl.sv
// option22_seq_ctrl: round-robin byte read/write access controller for a rotating serial buffer.
// Mirrors the buffer's rotation position and drives write/din while the target word passes.
module option22_seq_ctrl #(
  parameter int WORD_COUNT = 64,
  parameter int ADDR_W     = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_write,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [15:0]           req_wdata,
  output logic [1:0]            req_ready,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic [7:0]            rsp_rdata,
  output logic                  buf_reset,
  output logic                  buf_write,
  output logic                  buf_din,
  input  logic [7:0]            buf_byte
);
  localparam int PW = $clog2(WORD_COUNT) + 3;
  typedef enum logic [1:0] {IDLE, WAIT, XFER, RESP} state_t;
  state_t              r_state;
  logic [PW-1:0]       r_pos;
  logic                r_last, r_wr, r_id;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_wdata;
  logic                w_g, w_pre;
  logic [2:0]          w_phase;
  assign buf_reset = ~reset;
  assign w_g       = &req_valid ? ~r_last : req_valid[1];
  assign w_phase   = r_pos[2:0];
  // one cycle early so the registered write/din line up with the word's first bit
  assign w_pre     = (r_pos + PW'(1)) == {r_addr, 3'b000};
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_pos     <= '0;
      r_last    <= 1'b1;
      r_wr      <= 1'b0;
      r_id      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      req_ready <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_rdata <= '0;
      buf_write <= 1'b0;
      buf_din   <= 1'b0;
    end else begin
      r_pos     <= r_pos + PW'(1);
      req_ready <= '0;
      rsp_valid <= 1'b0;
      case (r_state)
        IDLE: if (|req_valid) begin
          req_ready <= w_g ? 2'b10 : 2'b01;
          r_last    <= w_g;
          r_id      <= w_g;
          r_wr      <= w_g ? req_write[1] : req_write[0];
          r_addr    <= w_g ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
          r_wdata   <= w_g ? req_wdata[15:8] : req_wdata[7:0];
          r_state   <= WAIT;
        end
        WAIT: if (w_pre) begin
          buf_write <= r_wr;
          buf_din   <= r_wr & r_wdata[7];
          r_state   <= XFER;
        end
        XFER: if (w_phase == 3'd7) begin
          buf_write <= 1'b0;
          buf_din   <= 1'b0;
          r_state   <= RESP;
        end else begin
          buf_din   <= r_wr & r_wdata[3'd6 - w_phase];
        end
        RESP: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= buf_byte;
          rsp_id    <= r_id;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/option22_seq_ctrl.md
Name: option22_seq_ctrl

Overview:
Access controller for the 64-word x 8-bit rotating serial buffer. The buffer shifts one bit per clock; a full lap is 512 cycles and it presents a byte every 8 cycles. This block mirrors the buffer's rotation position, arbitrates byte read/write requests from two requesters round-robin, and drives the buffer's write/din pins during the target word's slot. It returns the word's byte on a shared response channel.

Parameters:
WORD_COUNT, 64, words in the buffer; must match the buffer instance (power of two)
ADDR_W, 6, log2(WORD_COUNT)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
req_valid  in  2  per-requester request valid; [i] = requester i
req_write  in  2  per-requester: 1 = write, 0 = read
req_addr  in  2*ADDR_W  per-requester word address; requester i uses bits [i*ADDR_W +: ADDR_W]
req_wdata  in  16  per-requester write byte; requester i uses bits [i*8 +: 8]
req_ready  out  2  grant/accept; request i is accepted when req_valid[i] & req_ready[i]
rsp_valid  out  1  one-cycle completion pulse
rsp_id  out  1  requester that owns the response
rsp_rdata  out  8  word byte after the access (read data, or the byte just written)
buf_reset  out  1  active-high buffer reset, equal to ~reset (combinational, the only combinational output)
buf_write  out  1  buffer write enable
buf_din  out  1  buffer serial data in
buf_byte  in  8  buffer parallel output byte

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (reset=0).
- Reset values: state IDLE; pos=0; rr pointer favours requester 0; req_ready=0; rsp_valid=0; rsp_id=0; rsp_rdata=0; buf_write=0; buf_din=0.
- buf_reset=~reset, so the buffer's bit counter and pos leave reset on the same edge.
- Position counter pos:
  - 9 bits, increments every cycle, wraps 511->0.
  - phase = pos[2:0] equals the buffer's bit counter; slot = pos[8:3].
  - Word a passes the buffer input during pos 8a..8a+7 on every lap.
- State machine IDLE, WAIT, XFER, RESP:
  - IDLE:
    - If any req_valid, grant one requester: req_ready[g]=1 this cycle only.
    - Latch write, addr, wdata and g at the edge; go to WAIT.
    - Both valid: grant the requester not granted last. After reset, requester 0 wins.
  - WAIT:
    - On the first cycle with pos == {addr,3'b000}, enter XFER behaviour that same cycle; XFER spans pos 8a..8a+7.
    - Acceptance at pos=8a-1 gives zero wait.
    - Acceptance during slot a (phase>0) waits a full lap.
  - XFER:
    - Write: buf_write=1, buf_din=wdata[7-phase] (MSB first).
    - Read: buf_write=0, so the buffer recirculates.
    - After phase 7, go to RESP.
  - RESP (cycle P+1, where P=8a+7):
    - Sample buf_byte, which now holds word a.
    - At the end edge: rsp_valid<=1, rsp_rdata<=buf_byte, rsp_id<=g.
    - rsp_valid is visible in cycle P+2 for exactly one cycle; state returns to IDLE.
- Outside XFER: buf_write=0 and buf_din=0.
- Only one request is outstanding at a time. req_ready=0 outside IDLE. Requesters hold valid and data until accepted and may drop them afterwards.
- Latency from the acceptance edge to the rsp_valid cycle: min 10, max 521 cycles.
- A new grant is possible in the same cycle rsp_valid is high (IDLE).
- Reset mid-operation:
  - Aborts the access; no response is issued.
  - The target word's contents are unspecified if aborted during XFER of a write.
  - All other words are preserved, since the buffer does not clear data on reset.

Test Plan:
- Reset, idle 512 cycles: buf_write never 1. buf_byte at each pos=8a+8 equals the prior lap's value at the same pos (recirculation holds).
- Req0 write addr=5 data=0xA5, accepted at pos=39 -> buf_write=1 during pos 40..47 with din bits 1,0,1,0,0,1,0,1. rsp_valid at pos=49 with rsp_rdata=0xA5, rsp_id=0.
- Req1 read addr=5 afterwards -> rsp_rdata=0xA5, rsp_id=1. Then read addr=63, accepted at pos=10 -> transfer at pos 504..511, rsp_valid at pos=1 (wrap).
- Both valid simultaneously after reset -> req0 granted first, req1 next; on the next contention req0 wins again only if req1 was granted last.
- Write addr=0 accepted at pos=3 -> waits until pos=0 of the next lap (509 cycles), then transfers.
- Reset asserted at pos=44 during a write -> rsp_valid never pulses, pos=0 and IDLE after release. Words other than the target keep their values on read-back.
